// File: rtl/id_fwd_scoreboard_if.sv
// ---------------------------------------------------------------------------
// id_fwd_scoreboard_if
//
// Purpose:
//   Bundles the decode-stage operand request, register-file read data,
//   downstream stage results and the resolved forwarding/stall outputs of
//   id_fwd_scoreboard into one interface.
//
// Parameters:
//   XLEN     datapath width
//   NSTAGES  number of tracked stages after ID (0 = EX, NSTAGES-1 = WB)
//   SELW     forward-select width, derived from NSTAGES
//
// Signals (direction seen from the slave, i.e. the scoreboard):
//   in  id_valid_inst, id_ra_idx, id_rb_idx, id_uses_ra, id_uses_rb,
//       id_reg_wr, id_rd_mem, id_dest_reg_idx, flush
//   in  regf_rda, regf_rdb            register-file read data
//   in  stage_result, stage_data_ok   per-stage result and ready flags
//   out id_ra_value_out, id_rb_value_out, fwd_sel_a, fwd_sel_b
//   out stall_out, issue_out, stall_cycles_out
//
// Modports:
//   master  driven by the decode stage / testbench
//   slave   used by the scoreboard
// ---------------------------------------------------------------------------
interface id_fwd_scoreboard_if #(
    parameter int XLEN    = 32,
    parameter int NSTAGES = 3
);
    localparam int SELW = $clog2(NSTAGES + 1);

    logic                    id_valid_inst;
    logic [4:0]              id_ra_idx;
    logic [4:0]              id_rb_idx;
    logic                    id_uses_ra;
    logic                    id_uses_rb;
    logic                    id_reg_wr;
    logic                    id_rd_mem;
    logic [4:0]              id_dest_reg_idx;
    logic                    flush;
    logic [XLEN-1:0]         regf_rda;
    logic [XLEN-1:0]         regf_rdb;
    logic [NSTAGES*XLEN-1:0] stage_result;
    logic [NSTAGES-1:0]      stage_data_ok;

    logic [XLEN-1:0]         id_ra_value_out;
    logic [XLEN-1:0]         id_rb_value_out;
    logic [SELW-1:0]         fwd_sel_a;
    logic [SELW-1:0]         fwd_sel_b;
    logic                    stall_out;
    logic                    issue_out;
    logic [15:0]             stall_cycles_out;

    modport master (
        output id_valid_inst, id_ra_idx, id_rb_idx, id_uses_ra, id_uses_rb,
               id_reg_wr, id_rd_mem, id_dest_reg_idx, flush,
               regf_rda, regf_rdb, stage_result, stage_data_ok,
        input  id_ra_value_out, id_rb_value_out, fwd_sel_a, fwd_sel_b,
               stall_out, issue_out, stall_cycles_out
    );

    modport slave (
        input  id_valid_inst, id_ra_idx, id_rb_idx, id_uses_ra, id_uses_rb,
               id_reg_wr, id_rd_mem, id_dest_reg_idx, flush,
               regf_rda, regf_rdb, stage_result, stage_data_ok,
        output id_ra_value_out, id_rb_value_out, fwd_sel_a, fwd_sel_b,
               stall_out, issue_out, stall_cycles_out
    );
endinterface

// File: rtl/id_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// id_fwd_scoreboard
//
// Purpose:
//   Decode-stage operand hazard unit. Tracks the destination register of
//   every instruction in the NSTAGES stages after ID in a shift-register
//   scoreboard, resolves rs1/rs2 from the youngest in-flight producer (or
//   the register file), and stalls decode when that producer's result is
//   not final yet. Also counts stall cycles (saturating, 16 bit).
//
// Configuration macro:
//   FWD_BYPASS_EN  defined   -> full forwarding from any tracked stage
//                  undefined -> interlock only: selects stay 0, values come
//                               from the register file and any in-flight
//                               producer of a source operand stalls decode
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous, active-low reset
//   bus   slave modport of id_fwd_scoreboard_if (operand request, regfile
//         data, stage results in; resolved values, selects, stall, issue,
//         stall counter out)
// ---------------------------------------------------------------------------
module id_fwd_scoreboard #(
    parameter  int XLEN    = 32,
    parameter  int NSTAGES = 3,
    localparam int SELW    = $clog2(NSTAGES + 1)
) (
    input logic              clk,
    input logic              rst,
    id_fwd_scoreboard_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] dest;
        logic       load;
    } sb_entry_t;

    sb_entry_t          r_sb [NSTAGES];
    logic [15:0]        r_stall_cnt;

    logic [NSTAGES-1:0] w_match_a;
    logic [NSTAGES-1:0] w_match_b;
    logic [SELW-1:0]    w_sel_a;
    logic [SELW-1:0]    w_sel_b;
    logic [XLEN-1:0]    w_val_a;
    logic [XLEN-1:0]    w_val_b;
    logic               w_wait_a;
    logic               w_wait_b;
    logic               w_stall;
    logic               w_issue;
    logic [NSTAGES-1:0] w_unused_load;
    logic               w_unused;

    // A stage only counts as a producer for an operand the instruction
    // really reads; x0 is hard-wired zero and never matches.
    always_comb begin
        w_match_a     = '0;
        w_match_b     = '0;
        w_unused_load = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            w_match_a[k] = r_sb[k].valid && r_sb[k].wr &&
                           (r_sb[k].dest == bus.id_ra_idx) &&
                           (bus.id_ra_idx != 5'd0) && bus.id_uses_ra;
            w_match_b[k] = r_sb[k].valid && r_sb[k].wr &&
                           (r_sb[k].dest == bus.id_rb_idx) &&
                           (bus.id_rb_idx != 5'd0) && bus.id_uses_rb;
            w_unused_load[k] = r_sb[k].load;
        end
    end

`ifdef FWD_BYPASS_EN
    // Walk from oldest to youngest so the youngest match is the one left
    // standing. The select/value still point at that stage while it is not
    // ready; downstream ignores them because stall_out is high.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_val_a  = bus.regf_rda;
        w_val_b  = bus.regf_rdb;
        w_wait_a = 1'b0;
        w_wait_b = 1'b0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (w_match_a[k]) begin
                w_sel_a  = SELW'(k + 1);
                w_val_a  = bus.stage_result[k*XLEN +: XLEN];
                w_wait_a = ~bus.stage_data_ok[k];
            end
            if (w_match_b[k]) begin
                w_sel_b  = SELW'(k + 1);
                w_val_b  = bus.stage_result[k*XLEN +: XLEN];
                w_wait_b = ~bus.stage_data_ok[k];
            end
        end
    end

    assign w_unused = ^w_unused_load;
`else
    // Interlock only: any in-flight producer blocks until it has retired.
    assign w_sel_a  = '0;
    assign w_sel_b  = '0;
    assign w_val_a  = bus.regf_rda;
    assign w_val_b  = bus.regf_rdb;
    assign w_wait_a = |w_match_a;
    assign w_wait_b = |w_match_b;

    assign w_unused = ^{w_unused_load, bus.stage_result, bus.stage_data_ok};
`endif

    // flush wins over a stall so a killed instruction never holds decode.
    assign w_stall = bus.id_valid_inst & ~bus.flush & (w_wait_a | w_wait_b);
    assign w_issue = bus.id_valid_inst & ~bus.flush & ~w_stall;

    assign bus.fwd_sel_a        = w_sel_a;
    assign bus.fwd_sel_b        = w_sel_b;
    assign bus.id_ra_value_out  = w_val_a;
    assign bus.id_rb_value_out  = w_val_b;
    assign bus.stall_out        = w_stall;
    assign bus.issue_out        = w_issue;
    assign bus.stall_cycles_out = r_stall_cnt;

    // Scoreboard advances every cycle in lockstep with the pipeline; a
    // stalled or flushed instruction enters EX as a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NSTAGES; k++) begin
                r_sb[k] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            for (int k = NSTAGES - 1; k > 0; k--) begin
                r_sb[k] <= r_sb[k-1];
            end
            if (w_issue) begin
                r_sb[0] <= {1'b1, bus.id_reg_wr, bus.id_dest_reg_idx, bus.id_rd_mem};
            end else begin
                r_sb[0] <= '0;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_fwd_scoreboard
//
// Purpose:
//   Self-checking bench for id_fwd_scoreboard (XLEN = 32, NSTAGES = 3).
//   Works in both builds; FWD_BYPASS_EN selects forwarding expectations.
//   A directed vector table covers back-to-back forwarding, load-use and
//   x0; hand sequences cover youngest-wins, flush during stall, counter
//   saturation and reset asserted mid-stall; a random phase is compared
//   against a timestamp-based model of in-flight producers.
// ---------------------------------------------------------------------------
module tb_id_fwd_scoreboard;

    localparam int XLEN = 32;
    localparam int NST  = 3;
`ifdef FWD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ua;
        logic        ub;
        logic        wr;
        logic        ld;
        logic [4:0]  rd;
        logic        flush;
        logic [31:0] rda;
        logic [31:0] rdb;
        logic [95:0] res;
        logic [2:0]  ok;
    } stim_t;

    typedef struct {
        bit          rstFirst;
        stim_t       s;
        logic [1:0]  eSelA;
        logic [1:0]  eSelB;
        logic [31:0] eValA;
        logic [31:0] eValB;
        logic        eStall;
        logic        eIssue;
        logic [15:0] eCnt;
    } vec_t;

    typedef struct {
        int         issueCyc;
        logic       wr;
        logic [4:0] dest;
    } inflight_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    // Reference model state: every issued instruction with the cycle it
    // issued in; its stage is simply how many edges have passed since.
    inflight_t   inflight[$];
    int          cyc;
    logic [15:0] cntModel;

    logic [1:0]  mSelA;
    logic [1:0]  mSelB;
    logic [31:0] mValA;
    logic [31:0] mValB;
    logic        mStall;
    logic        mIssue;

    id_fwd_scoreboard_if #(.XLEN(XLEN), .NSTAGES(NST)) bus ();

    id_fwd_scoreboard #(.XLEN(XLEN), .NSTAGES(NST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mkStim(input logic valid, input logic [4:0] ra, input logic [4:0] rb,
                                     input logic ua, input logic ub, input logic wr, input logic ld,
                                     input logic [4:0] rd, input logic flush, input logic [31:0] rda,
                                     input logic [31:0] rdb, input logic [95:0] res, input logic [2:0] ok);
        stim_t s;
        s.valid = valid; s.ra = ra; s.rb = rb; s.ua = ua; s.ub = ub; s.wr = wr; s.ld = ld;
        s.rd = rd; s.flush = flush; s.rda = rda; s.rdb = rdb; s.res = res; s.ok = ok;
        return s;
    endfunction

    task automatic driveBus(input stim_t s);
        bus.id_valid_inst   = s.valid;
        bus.id_ra_idx       = s.ra;
        bus.id_rb_idx       = s.rb;
        bus.id_uses_ra      = s.ua;
        bus.id_uses_rb      = s.ub;
        bus.id_reg_wr       = s.wr;
        bus.id_rd_mem       = s.ld;
        bus.id_dest_reg_idx = s.rd;
        bus.flush           = s.flush;
        bus.regf_rda        = s.rda;
        bus.regf_rdb        = s.rdb;
        bus.stage_result    = s.res;
        bus.stage_data_ok   = s.ok;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        driveBus(s);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkVec(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [31:0] va, input logic [31:0] vb, input logic st,
                            input logic is, input logic [15:0] cnt);
        checkOutput({tag, ".selA"},  32'(bus.fwd_sel_a),        32'(sa));
        checkOutput({tag, ".selB"},  32'(bus.fwd_sel_b),        32'(sb));
        checkOutput({tag, ".valA"},  bus.id_ra_value_out,       va);
        checkOutput({tag, ".valB"},  bus.id_rb_value_out,       vb);
        checkOutput({tag, ".stall"}, 32'(bus.stall_out),        32'(st));
        checkOutput({tag, ".issue"}, 32'(bus.issue_out),        32'(is));
        checkOutput({tag, ".cnt"},   32'(bus.stall_cycles_out), 32'(cnt));
    endtask

    task automatic doReset();
        @(negedge clk);
        driveBus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 3'b111));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        inflight.delete();
        cyc      = 0;
        cntModel = '0;
    endtask

    // Youngest in-flight writer of idx decides the outcome for one operand.
    task automatic modelOperand(input logic [4:0] idx, input logic uses, input logic [31:0] rf,
                                input logic [95:0] res, input logic [2:0] ok,
                                output logic [1:0] sel, output logic [31:0] val, output logic blocked);
        int stage;
        stage   = -1;
        sel     = 2'd0;
        val     = rf;
        blocked = 1'b0;
        if (uses && idx != 5'd0) begin
            for (int i = 0; i < inflight.size(); i++) begin
                int age;
                age = cyc - inflight[i].issueCyc - 1;
                if (age >= 0 && age < NST && inflight[i].wr && inflight[i].dest == idx)
                    stage = age;
            end
        end
        if (stage >= 0) begin
            if (BYP) begin
                sel     = 2'(stage + 1);
                val     = res[stage*32 +: 32];
                blocked = ~ok[stage];
            end else begin
                blocked = 1'b1;
            end
        end
    endtask

    task automatic modelEval(input stim_t s);
        logic bA;
        logic bB;
        modelOperand(s.ra, s.ua, s.rda, s.res, s.ok, mSelA, mValA, bA);
        modelOperand(s.rb, s.ub, s.rdb, s.res, s.ok, mSelB, mValB, bB);
        mStall = s.valid & ~s.flush & (bA | bB);
        mIssue = s.valid & ~s.flush & ~mStall;
    endtask

    task automatic modelCommit(input stim_t s);
        inflight_t e;
        if (mIssue) begin
            e.issueCyc = cyc;
            e.wr       = s.wr;
            e.dest     = s.rd;
            inflight.push_back(e);
        end
        if (mStall && cntModel != 16'hFFFF) cntModel++;
        cyc++;
        while (inflight.size() > 0 && (cyc - inflight[0].issueCyc - 1) >= NST)
            void'(inflight.pop_front());
    endtask

    initial begin
        vec_t  vecs[10];
        stim_t s;
        stim_t sat;
        int    extra;
        logic [95:0] resA;
        logic [95:0] resB;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        cntModel    = '0;
        resA = {32'h0000_000C, 32'h0000_000B, 32'h0000_1234};
        resB = {32'h0000_0099, 32'h0000_0077, 32'hDEAD_0000};

        // ADD x5 then ADD x6,x5,x0 repeated: forward from stages 0/1/2,
        // or three interlock stall cycles without bypass.
        vecs[0] = '{1'b1, mkStim(1, 1, 2, 1, 1, 1, 0, 5, 0, 32'd11, 32'd22, resA, 3'b111),
                    2'd0, 2'd0, 32'd11, 32'd22, 1'b0, 1'b1, 16'd0};
        vecs[1] = '{1'b0, mkStim(1, 5, 0, 1, 1, 1, 0, 6, 0, 32'h55, 32'h0, resA, 3'b111),
                    BYP ? 2'd1 : 2'd0, 2'd0, BYP ? 32'h1234 : 32'h55, 32'h0, !BYP, BYP, 16'd0};
        vecs[2] = '{1'b0, mkStim(1, 5, 0, 1, 1, 1, 0, 6, 0, 32'h55, 32'h0, resA, 3'b111),
                    BYP ? 2'd2 : 2'd0, 2'd0, BYP ? 32'hB : 32'h55, 32'h0, !BYP, BYP, BYP ? 16'd0 : 16'd1};
        vecs[3] = '{1'b0, mkStim(1, 5, 0, 1, 1, 1, 0, 6, 0, 32'h55, 32'h0, resA, 3'b111),
                    BYP ? 2'd3 : 2'd0, 2'd0, BYP ? 32'hC : 32'h55, 32'h0, !BYP, BYP, BYP ? 16'd0 : 16'd2};
        vecs[4] = '{1'b0, mkStim(1, 5, 0, 1, 1, 1, 0, 6, 0, 32'h55, 32'h0, resA, 3'b111),
                    2'd0, 2'd0, 32'h55, 32'h0, 1'b0, 1'b1, BYP ? 16'd0 : 16'd3};
        // LW x7 then ADD x8,x7,x7: one load-use stall, then forward from MEM.
        vecs[5] = '{1'b1, mkStim(1, 1, 2, 1, 1, 1, 1, 7, 0, 32'd1, 32'd2, resB, 3'b111),
                    2'd0, 2'd0, 32'd1, 32'd2, 1'b0, 1'b1, 16'd0};
        vecs[6] = '{1'b0, mkStim(1, 7, 7, 1, 1, 1, 0, 8, 0, 32'h70, 32'h71, resB, 3'b110),
                    BYP ? 2'd1 : 2'd0, BYP ? 2'd1 : 2'd0, BYP ? 32'hDEAD_0000 : 32'h70,
                    BYP ? 32'hDEAD_0000 : 32'h71, 1'b1, 1'b0, 16'd0};
        vecs[7] = '{1'b0, mkStim(1, 7, 7, 1, 1, 1, 0, 8, 0, 32'h70, 32'h71, resB, 3'b110),
                    BYP ? 2'd2 : 2'd0, BYP ? 2'd2 : 2'd0, BYP ? 32'h77 : 32'h70,
                    BYP ? 32'h77 : 32'h71, !BYP, BYP, 16'd1};
        // Producer writes x0, consumer reads x0: never forwarded, never stalls.
        vecs[8] = '{1'b1, mkStim(1, 1, 2, 1, 1, 1, 0, 0, 0, 32'd3, 32'd4, resB, 3'b111),
                    2'd0, 2'd0, 32'd3, 32'd4, 1'b0, 1'b1, 16'd0};
        vecs[9] = '{1'b0, mkStim(1, 0, 0, 1, 1, 1, 0, 9, 0, 32'd0, 32'd0, resB, 3'b000),
                    2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 16'd0};

        // Outputs while held in reset with a hazard-looking request.
        rst = 1'b0;
        driveBus(mkStim(1, 5, 6, 1, 1, 1, 1, 5, 0, 32'hA5A5_0001, 32'hA5A5_0002, resA, 3'b000));
        #3;
        checkVec("reset", 2'd0, 2'd0, 32'hA5A5_0001, 32'hA5A5_0002, 1'b0, 1'b1, 16'd0);
        bus.flush = 1'b1;
        #1;
        checkOutput("reset.issueFlush", 32'(bus.issue_out), 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rstFirst) doReset();
            applyStimulus(vecs[i].s);
            checkVec($sformatf("vec%0d", i), vecs[i].eSelA, vecs[i].eSelB, vecs[i].eValA,
                     vecs[i].eValB, vecs[i].eStall, vecs[i].eIssue, vecs[i].eCnt);
        end

        // Writers of x3 end up in entries 0 and 2; the youngest must win.
        doReset();
        applyStimulus(mkStim(1, 1, 2, 1, 1, 1, 0, 3, 0, 32'd1, 32'd2, '0, 3'b111));
        applyStimulus(mkStim(1, 1, 2, 1, 1, 1, 0, 9, 0, 32'd1, 32'd2, '0, 3'b111));
        applyStimulus(mkStim(1, 1, 2, 1, 1, 1, 0, 3, 0, 32'd1, 32'd2, '0, 3'b111));
        applyStimulus(mkStim(1, 3, 0, 1, 0, 0, 0, 0, 0, 32'h33, 32'h0,
                             {32'hBB, 32'h99, 32'hAA}, 3'b111));
        checkOutput("young.selA",  32'(bus.fwd_sel_a), BYP ? 32'd1 : 32'd0);
        checkOutput("young.valA",  bus.id_ra_value_out, BYP ? 32'hAA : 32'h33);
        checkOutput("young.stall", 32'(bus.stall_out), BYP ? 32'd0 : 32'd1);
        checkOutput("young.issue", 32'(bus.issue_out), BYP ? 32'd1 : 32'd0);

        // Flush during a hazard stall: the killed instruction becomes a bubble.
        doReset();
        applyStimulus(mkStim(1, 1, 2, 1, 1, 1, 1, 7, 0, 32'd1, 32'd2, '0, 3'b000));
        checkOutput("flush.prodIssue", 32'(bus.issue_out), 32'd1);
        applyStimulus(mkStim(1, 7, 2, 1, 0, 1, 0, 9, 0, 32'h70, 32'h0, '0, 3'b000));
        checkOutput("flush.stallBefore", 32'(bus.stall_out), 32'd1);
        applyStimulus(mkStim(1, 7, 2, 1, 0, 1, 0, 9, 1, 32'h70, 32'h0, '0, 3'b000));
        checkOutput("flush.stall", 32'(bus.stall_out), 32'd0);
        checkOutput("flush.issue", 32'(bus.issue_out), 32'd0);
        applyStimulus(mkStim(1, 9, 0, 1, 0, 0, 0, 0, 0, 32'h90, 32'h0, '0, 3'b000));
        checkOutput("flush.bubbleStall", 32'(bus.stall_out), 32'd0);
        checkOutput("flush.bubbleSel",   32'(bus.fwd_sel_a), 32'd0);
        checkOutput("flush.bubbleVal",   bus.id_ra_value_out, 32'h90);
        checkOutput("flush.cnt",         32'(bus.stall_cycles_out), 32'd1);

        // Random traffic over a small register window to provoke hazards.
        doReset();
        for (int n = 0; n < 400; n++) begin
            s = mkStim($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                       $urandom, $urandom, {$urandom, $urandom, $urandom},
                       {$urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7});
            applyStimulus(s);
            modelEval(s);
            checkVec($sformatf("rand%0d", n), mSelA, mSelB, mValA, mValB, mStall, mIssue, cntModel);
            modelCommit(s);
        end

        // Self-dependent load stream: three stall cycles per issue, long
        // enough to drive the counter into saturation.
        doReset();
        sat   = mkStim(1, 7, 7, 1, 0, 1, 1, 7, 0, 32'h70, 32'h0, {32'h3, 32'h2, 32'h1}, 3'b000);
        extra = 0;
        for (int n = 0; n < 90000; n++) begin
            applyStimulus(sat);
            modelEval(sat);
            if (cntModel == 16'hFFFE || extra > 0)
                checkOutput("sat.cnt", 32'(bus.stall_cycles_out), 32'(cntModel));
            if (cntModel == 16'hFFFF && mStall) extra++;
            modelCommit(sat);
            if (extra >= 6) break;
        end
        if (cntModel != 16'hFFFF) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL sat.bound: model count %h, required ffff within cycle budget", cntModel);
        end

        // Land on a stall cycle, then pull reset low in the middle of it.
        for (int n = 0; n < 4; n++) begin
            applyStimulus(sat);
            modelEval(sat);
            if (mStall) break;
            modelCommit(sat);
        end
        checkOutput("sat.final",         32'(bus.stall_cycles_out), 32'hFFFF);
        checkOutput("midRst.stallBefore", 32'(bus.stall_out), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkVec("midRst", 2'd0, 2'd0, 32'h70, 32'h0, 1'b0, 1'b1, 16'd0);
        @(negedge clk);
        driveBus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 3'b111));
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
